aes_decrypt_seq: RTL
====================

# aes_decrypt_seq

Iterative AES-128 decryption sequencer. It owns the block-level handshake and schedules one registered inverse round stage and one registered inverse final-round stage, both external, over ten rounds. It reads round keys by index from the external key-schedule store and returns one plaintext block per accepted ciphertext block. It sits between the host stream interface and the decrypt datapath; only one block is in flight at a time.

## Interface
- No parameters; the block is fixed to AES-128 (Nr = 10, 128-bit block).
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block can be accepted
- in_data  in  128  ciphertext
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext (registered)
- key_valid  in  1  key schedule expanded and stable
- key_idx  out  4  round-key index, 0..10
- key_data  in  128  round key at key_idx (combinational read, same cycle)
- rnd_in  out  128  state into the inverse round stage (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; 1-cycle registered)
- rnd_key  out  128  key into the inverse round stage
- rnd_out  in  128  inverse round stage output
- last_in  out  128  state into the final stage (InvShiftRows, InvSubBytes, AddRoundKey; 1-cycle registered)
- last_key  out  128  key into the final stage
- last_out  in  128  final stage output
- busy  out  1  high in any state except IDLE
- round  out  4  current round counter, for debug
- blk_cnt  out  32  completed blocks, wraps modulo 2^32

## Operation
- States: IDLE, ROUND, LAST, CAPT, DONE.
- IDLE: key_idx = 10. in_ready = key_valid. On in_valid & in_ready, load s_reg <= in_data ^ key_data (initial AddRoundKey), set round <= 9, and go to ROUND.
- ROUND: key_idx = round. rnd_key = key_data. rnd_in = s_reg when round == 9, else rnd_out. round decrements each cycle. When round == 1, go to LAST.
- LAST: key_idx = 0. last_in = rnd_out. last_key = key_data. Go to CAPT.
- CAPT: out_data <= last_out, out_valid <= 1, blk_cnt <= blk_cnt + 1, then go to DONE.
- DONE: out_data and out_valid are held. On out_ready, clear out_valid and go to IDLE.
- key_idx in CAPT and DONE is 0. rnd_in and last_in are don't-care outside their own states but must be driven (0 is acceptable).
- The key schedule is required to remain stable while busy. Deassertion of key_valid while busy is ignored.
- in_ready is 0 in every state except IDLE. There is no overlap between blocks.

## Timing
- Reset values: state IDLE; out_valid 0; out_data 0; s_reg 0; round 0; blk_cnt 0; busy 0. in_ready follows key_valid immediately after reset.
- Let edge E0 accept the block. The cycle after each edge:
  - E0 → ROUND, round 9.
  - E1 … E8 → ROUND, round 8 … 1.
  - E9 → LAST.
  - E10 → CAPT.
  - E11 → DONE, out_valid = 1.
- Latency is 11 edges from accept to out_valid high.
- If out_ready is already high when out_valid rises, the handshake completes at E12 and in_ready is high again in the following cycle. Minimum block period is 13 cycles.
- out_valid stays high until out_ready is sampled high. out_data does not change while out_valid is high.
- in_valid asserted while busy has no effect, and in_data is not sampled.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The in-flight block is discarded and blk_cnt is not incremented.
- blk_cnt wraps from 0xFFFFFFFF to 0.

## Test plan
- FIPS-197 C.1 vector. Key schedule from 000102030405060708090a0b0c0d0e0f; in_data 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid at E11, blk_cnt 1.
- key_idx trace. Over one block, key_idx sequence per cycle is 10, 9, 8, … 1, 0; rnd_in equals s_reg only in the round-9 cycle.
- Backpressure. Hold out_ready low 20 cycles after out_valid → out_data stable, in_ready 0. Raise out_ready → IDLE, and a second block is accepted one cycle later.
- key_valid low with in_valid high → in_ready 0, no acceptance, busy stays 0.
- Reset at the round-5 cycle → out_valid 0 and state IDLE immediately. The next block decrypts correctly and blk_cnt reads 1, not 2.
- Back-to-back. Three FIPS blocks with out_ready tied high → three correct outputs, 13-cycle spacing, blk_cnt 3.

Source files
------------

// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 decryption sequencer.
// Owns the block handshake and walks one ciphertext block through ten inverse
// rounds. The external round stage is used for rounds 9..1, and the external
// final stage for round 0. Both stages are registered. Round keys come from
// the external key store by index, and the read is combinational.
// Only one block is in flight at a time.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for a ciphertext block; key index parked at 10
//  ROUND | feeding the inverse round stage, round counts 9 down to 1
//  LAST  | feeding the inverse final stage with round key 0
//  CAPT  | capturing the final stage result into out_data
//  DONE  | holding plaintext until the consumer takes it
module aes_decrypt_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         key_valid,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_data,
    output logic [127:0] rnd_in,
    output logic [127:0] rnd_key,
    input  logic [127:0] rnd_out,
    output logic [127:0] last_in,
    output logic [127:0] last_key,
    input  logic [127:0] last_out,
    output logic         busy,
    output logic [3:0]   round,
    output logic [31:0]  blk_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROUND = 3'd1,
        LAST  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state;
    logic [127:0] s_reg;
    logic [3:0]   round_q;

    // Sequencer: block acceptance, round down-counter, result capture and output hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_reg     <= '0;
            round_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            blk_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && key_valid) begin
                        // Initial AddRoundKey with round key 10 is folded into the load
                        s_reg   <= in_data ^ key_data;
                        round_q <= 4'd9;
                        state   <= ROUND;
                    end
                end
                ROUND: begin
                    round_q <= round_q - 4'd1;
                    if (round_q == 4'd1) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_data  <= last_out;
                    out_valid <= 1'b1;
                    blk_cnt   <= blk_cnt + 32'd1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign round = round_q;
    assign busy  = (state != IDLE);

    // Key index and stage operand steering; unused stage inputs are held at zero
    always_comb begin
        in_ready = 1'b0;
        key_idx  = 4'd0;
        rnd_in   = '0;
        rnd_key  = '0;
        last_in  = '0;
        last_key = '0;
        case (state)
            IDLE: begin
                in_ready = key_valid;
                key_idx  = 4'd10;
            end
            ROUND: begin
                key_idx = round_q;
                rnd_key = key_data;
                // First inverse round works on the loaded state; later rounds
                // chain straight off the stage's registered output
                rnd_in  = (round_q == 4'd9) ? s_reg : rnd_out;
            end
            LAST: begin
                key_idx  = 4'd0;
                last_in  = rnd_out;
                last_key = key_data;
            end
            default: begin
                key_idx = 4'd0;
            end
        endcase
    end

endmodule
